// File: rtl/cla_serial_adder.sv
// Multi-cycle wide adder: resolves one CHUNK-bit slice per clock with a
// parallel-prefix carry network and accumulates word-level group G/P.
module cla_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             g_grp,
  output logic             p_grp
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LVLS  = $clog2(CHUNK);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, sum_acc, sum_nxt;
  logic             cin_reg, carry_reg, g_acc, p_acc;
  logic [IDX_W-1:0] idx;
  logic [CHUNK-1:0] a_sl, b_sl, g_bit, p_bit, g_pre, p_pre, carries, sl_sum;
  logic             sl_cout, g_acc_nxt, p_acc_nxt;
  logic             accept, last;

  function automatic logic signed_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (idx == IDX_W'(NCH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == BUSY);
    done = (state == DONE);
  end

  // Slice stage: Kogge-Stone prefix over the current slice, seeded by carry_reg.
  always_comb begin
    logic [CHUNK-1:0] g_tmp, p_tmp;
    a_sl  = a_reg[idx*CHUNK +: CHUNK];
    b_sl  = b_reg[idx*CHUNK +: CHUNK];
    g_bit = a_sl & b_sl;
    p_bit = a_sl ^ b_sl;
    g_pre = g_bit;
    p_pre = p_bit;
    g_tmp = g_bit;
    p_tmp = p_bit;
    for (int l = 0; l < LVLS; l++) begin
      g_tmp = g_pre;
      p_tmp = p_pre;
      for (int i = 0; i < CHUNK; i++) begin
        if (i >= (1 << l)) begin
          g_tmp[i] = g_pre[i] | (p_pre[i] & g_pre[i - (1 << l)]);
          p_tmp[i] = p_pre[i] & p_pre[i - (1 << l)];
        end
      end
      g_pre = g_tmp;
      p_pre = p_tmp;
    end
    carries[0] = carry_reg;
    for (int i = 1; i < CHUNK; i++)
      carries[i] = g_pre[i-1] | (p_pre[i-1] & carry_reg);
    sl_sum    = p_bit ^ carries;
    sl_cout   = g_pre[CHUNK-1] | (p_pre[CHUNK-1] & carry_reg);
    g_acc_nxt = g_pre[CHUNK-1] | (p_pre[CHUNK-1] & g_acc);
    p_acc_nxt = p_pre[CHUNK-1] & p_acc;
    sum_nxt   = sum_acc;
    sum_nxt[idx*CHUNK +: CHUNK] = sl_sum;
  end

  // Register stage: operand capture, slice carry chaining, result load on BUSY->DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      g_acc     <= 1'b0;
      p_acc     <= 1'b0;
      sum_acc   <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      g_grp     <= 1'b0;
      p_grp     <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      cin_reg   <= c_in;
      carry_reg <= c_in;
      idx       <= '0;
      g_acc     <= 1'b0;
      p_acc     <= 1'b1;
      sum_acc   <= '0;
    end else if (state == BUSY) begin
      sum_acc   <= sum_nxt;
      carry_reg <= sl_cout;
      g_acc     <= g_acc_nxt;
      p_acc     <= p_acc_nxt;
      if (last) begin
        sum   <= sum_nxt;
        c_out <= sl_cout;
        ovf   <= signed_ovf(a_reg[WIDTH-1], b_reg[WIDTH-1], sum_nxt[WIDTH-1]);
        g_grp <= g_acc_nxt;
        p_grp <= p_acc_nxt;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Bench for cla_serial_adder: directed adds checked against an arithmetic
// model every cycle, plus literal result checks on the specified vectors.
module tb_cla_serial_adder;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst, start, c_in;
  logic [31:0] a, b;
  logic        busy, done, c_out, ovf, g_grp, p_grp;
  logic [31:0] sum;

  cla_serial_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf),
    .g_grp(g_grp), .p_grp(p_grp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    int          due;
    logic [31:0] sum;
    logic        c_out, ovf, g_grp, p_grp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mc);
    exp_t        r;
    logic [32:0] s, gs;
    s  = {1'b0, ma} + {1'b0, mb} + 33'(mc);
    gs = {1'b0, ma} + {1'b0, mb};
    r.st    = 0;
    r.due   = 0;
    r.sum   = s[31:0];
    r.c_out = s[32];
    r.ovf   = (ma[31] == mb[31]) && (s[31] != ma[31]);
    r.g_grp = gs[32];
    r.p_grp = &(ma ^ mb);
    return r;
  endfunction

  // Per-cycle compare against the model; result outputs must hold between done pulses.
  initial begin
    logic        e_done, e_busy;
    logic [31:0] h_sum;
    logic        h_c, h_o, h_g, h_p;
    h_sum = '0; h_c = 0; h_o = 0; h_g = 0; h_p = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        h_sum = '0; h_c = 0; h_o = 0; h_g = 0; h_p = 0;
        e_done = 0;
        e_busy = 0;
      end else begin
        e_done = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
          e_done = 1;
          h_sum = q[0].sum; h_c = q[0].c_out; h_o = q[0].ovf;
          h_g = q[0].g_grp; h_p = q[0].p_grp;
          void'(q.pop_front());
        end
        e_busy = (q.size() > 0) && (cyc > q[0].st) && (cyc < q[0].due);
      end
      chk("done",  32'(done),  32'(e_done));
      chk("busy",  32'(busy),  32'(e_busy));
      chk("sum",   sum,        h_sum);
      chk("c_out", 32'(c_out), 32'(h_c));
      chk("ovf",   32'(ovf),   32'(h_o));
      chk("g_grp", 32'(g_grp), 32'(h_g));
      chk("p_grp", 32'(p_grp), 32'(h_p));
    end
  end

  task automatic drive_add(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc, input bit push);
    exp_t e;
    a = ta; b = tb_v; c_in = tc; start = 1'b1;
    if (push) begin
      e = model(ta, tb_v, tc);
      e.st  = cyc;
      e.due = cyc + NCH + 1;
      q.push_back(e);
    end
  endtask

  task automatic start_add(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc);
    @(negedge clk); #1;
    drive_add(ta, tb_v, tc, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic lit(input string tag, input logic [31:0] s, input logic c, input logic o,
                     input logic g, input logic p);
    chk({tag, "_done"},  32'(done),  32'd1);
    chk({tag, "_sum"},   sum,        s);
    chk({tag, "_c_out"}, 32'(c_out), 32'(c));
    chk({tag, "_ovf"},   32'(ovf),   32'(o));
    chk({tag, "_g_grp"}, 32'(g_grp), 32'(g));
    chk({tag, "_p_grp"}, 32'(p_grp), 32'(p));
  endtask

  logic [31:0] va[4] = '{32'h00000000, 32'h80000000, 32'hAAAAAAAA, 32'hDEADBEEF};
  logic [31:0] vb[4] = '{32'h00000000, 32'h80000000, 32'h55555555, 32'h21524110};
  logic        vc[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    idle(10);

    start_add(32'hFFFFFFFF, 32'h00000001, 1'b0);
    idle(5);
    lit("carry_wrap", 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);

    start_add(32'hFFFF0000, 32'h0000FFFF, 1'b1);
    idle(5);
    lit("full_prop", 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);

    start_add(32'h7FFFFFFF, 32'h00000001, 1'b0);
    idle(4);
    @(negedge clk); #1;
    lit("sgn_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_add(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
    idle(5);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_sum", sum, 32'hACF13568);
    chk("b2b_c_out", 32'(c_out), 32'd0);
    chk("b2b_ovf", 32'(ovf), 32'd0);

    start_add(32'h00000010, 32'h00000020, 1'b0);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      drive_add(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    end
    idle(1);
    lit("ignored_start", 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    start_add(32'h0F0F0F0F, 32'h01010101, 1'b0);
    idle(2);
    @(negedge clk); #1;
    rst = 1'b1;
    q.delete();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", sum, 32'h0);
    @(negedge clk); #1;
    rst = 1'b0;
    idle(6);

    start_add(32'h0F0F0F0F, 32'h01010101, 1'b0);
    idle(5);
    lit("post_rst", 32'h10101010, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      start_add(va[k], vb[k], vc[k]);
      idle(5);
    end

    idle(3);
    chk("pending_results", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
